bram_dp: RTL and testbench

Parametrised true dual-port block RAM. It replaces the single-port BRAM in the memory subsystem, with two independent request ports (A, B) sharing one storage array. Adds per-port valid/ready handshake, byte-lane write enables, configurable registered read latency, same-address write-collision arbitration and out-of-range detection. Sits between the core load/store and fetch/DMA paths and the on-chip storage.

---
 rtl/bram_pkg.sv | 22 ++
 rtl/bram_rd_pipe.sv | 44 ++++
 rtl/bram_dp.sv | 111 +++++++++++
 tb/tb_bram_dp.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// rtl/bram_pkg.sv - shared constants and elaboration helpers for bram_dp
package bram_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int BE_WIDTH = DEFAULT_DATA_WIDTH / 8;

  // Fill byte returned for reads beyond BRAM_DEPTH
  localparam logic [7:0] OOR_BYTE = 8'h00;

  function automatic int be_width(input int data_width);
    return data_width / 8;
  endfunction

  function automatic bit latency_legal(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

  function automatic bit width_legal(input int data_width);
    return (data_width > 0) && (data_width % 8 == 0);
  endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// rtl/bram_rd_pipe.sv - per-port read valid/data/err shift pipeline
module bram_rd_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_err,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dvalid,
  output logic                  err,
  output logic                  occupied
);

  logic [LATENCY-1:0]    v;
  logic [LATENCY-1:0]    e;
  logic [DATA_WIDTH-1:0] d [LATENCY];

  // Data stages only advance with a valid read so dout holds between reads
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      v <= '0;
      e <= '0;
      for (int i = 0; i < LATENCY; i++) d[i] <= '0;
    end else begin
      v[0] <= in_valid;
      e[0] <= in_valid & in_err;
      if (in_valid) d[0] <= in_data;
      for (int i = 1; i < LATENCY; i++) begin
        v[i] <= v[i-1];
        e[i] <= e[i-1];
        if (v[i-1]) d[i] <= d[i-1];
      end
    end
  end

  assign dout     = d[LATENCY-1];
  assign dvalid   = v[LATENCY-1];
  assign err      = e[LATENCY-1];
  assign occupied = |v;

endmodule

// File: rtl/bram_dp.sv
// rtl/bram_dp.sv - true dual-port block RAM with handshake, byte enables and collision arbitration
module bram_dp
  import bram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int BRAM_DEPTH   = 256,
  parameter int READ_LATENCY = 1,
  parameter     INIT_FILE    = ""
) (
  input  logic                              ck,
  input  logic                              rst,
  input  logic                              a_req,
  output logic                              a_ready,
  input  logic                              a_wen,
  input  logic [be_width(DATA_WIDTH)-1:0]   a_be,
  input  logic [ADDR_WIDTH-1:0]             a_addr,
  input  logic [DATA_WIDTH-1:0]             a_din,
  output logic [DATA_WIDTH-1:0]             a_dout,
  output logic                              a_dvalid,
  output logic                              a_err,
  input  logic                              b_req,
  output logic                              b_ready,
  input  logic                              b_wen,
  input  logic [be_width(DATA_WIDTH)-1:0]   b_be,
  input  logic [ADDR_WIDTH-1:0]             b_addr,
  input  logic [DATA_WIDTH-1:0]             b_din,
  output logic [DATA_WIDTH-1:0]             b_dout,
  output logic                              b_dvalid,
  output logic                              b_err,
  output logic                              busy
);

  localparam int                    BE_W     = be_width(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] OOR_DATA = {BE_W{OOR_BYTE}};
  localparam logic [ADDR_WIDTH:0]   DEPTH_L  = (ADDR_WIDTH+1)'(BRAM_DEPTH);

  if (!latency_legal(READ_LATENCY)) begin : g_bad_latency
    $error("bram_dp: READ_LATENCY must be 1 or 2");
  end
  if (!width_legal(DATA_WIDTH)) begin : g_bad_width
    $error("bram_dp: DATA_WIDTH must be a multiple of 8");
  end

  logic [DATA_WIDTH-1:0] mem [BRAM_DEPTH];

  logic                  up;
  logic                  collide, a_acc, b_acc, a_oor, b_oor;
  logic                  a_rq_v, a_rq_e, b_rq_v, b_rq_e, a_werr, b_werr;
  logic [DATA_WIDTH-1:0] a_rq_d, b_rq_d;
  logic                  a_rerr, b_rerr, a_occ, b_occ;

  always_ff @(posedge ck or posedge rst) begin
    if (rst) up <= 1'b0;
    else     up <= 1'b1;
  end

  // Same-address dual write: A goes first, B stalls and lands afterwards as last writer
  assign collide = a_req & a_wen & b_req & b_wen & (a_addr == b_addr);
  assign a_ready = up;
  assign b_ready = up & ~collide;
  assign a_acc   = a_req & a_ready;
  assign b_acc   = b_req & b_ready;
  assign a_oor   = {1'b0, a_addr} >= DEPTH_L;
  assign b_oor   = {1'b0, b_addr} >= DEPTH_L;

  // Non-blocking read of mem alongside the writes gives read-first cross-port behaviour
  always_ff @(posedge ck) begin
    if (a_acc & ~a_wen) a_rq_d <= a_oor ? OOR_DATA : mem[a_addr];
    if (b_acc & ~b_wen) b_rq_d <= b_oor ? OOR_DATA : mem[b_addr];
    if (a_acc & a_wen & ~a_oor)
      for (int i = 0; i < BE_W; i++)
        if (a_be[i]) mem[a_addr][8*i +: 8] <= a_din[8*i +: 8];
    if (b_acc & b_wen & ~b_oor)
      for (int i = 0; i < BE_W; i++)
        if (b_be[i]) mem[b_addr][8*i +: 8] <= b_din[8*i +: 8];
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      a_rq_v <= 1'b0;
      a_rq_e <= 1'b0;
      a_werr <= 1'b0;
      b_rq_v <= 1'b0;
      b_rq_e <= 1'b0;
      b_werr <= 1'b0;
    end else begin
      a_rq_v <= a_acc & ~a_wen;
      a_rq_e <= a_acc & ~a_wen & a_oor;
      a_werr <= a_acc & a_wen & a_oor;
      b_rq_v <= b_acc & ~b_wen;
      b_rq_e <= b_acc & ~b_wen & b_oor;
      b_werr <= b_acc & b_wen & b_oor;
    end
  end

  bram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .LATENCY(READ_LATENCY)) u_a_pipe (
    .ck(ck), .rst(rst), .in_valid(a_rq_v), .in_data(a_rq_d), .in_err(a_rq_e),
    .dout(a_dout), .dvalid(a_dvalid), .err(a_rerr), .occupied(a_occ)
  );

  bram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .LATENCY(READ_LATENCY)) u_b_pipe (
    .ck(ck), .rst(rst), .in_valid(b_rq_v), .in_data(b_rq_d), .in_err(b_rq_e),
    .dout(b_dout), .dvalid(b_dvalid), .err(b_rerr), .occupied(b_occ)
  );

  assign a_err = a_rerr | a_werr;
  assign b_err = b_rerr | b_werr;
  assign busy  = a_rq_v | b_rq_v | a_occ | b_occ | (up & b_req & ~b_ready);

endmodule

// File: tb/tb_bram_dp.sv
// tb/tb_bram_dp.sv - self-checking bench for bram_dp at latency 1/depth 256 and latency 2/depth 200
module tb_bram_dp;

  localparam int DW   = 32;
  localparam int AW   = 8;
  localparam int BW   = 4;
  localparam int NI   = 2;
  localparam int RING = 64;

  int depth [NI] = '{256, 200};
  int lat   [NI] = '{1, 2};

  logic          ck = 1'b0;
  logic          rst = 1'b1;
  logic          a_req = 1'b0, a_wen = 1'b0, b_req = 1'b0, b_wen = 1'b0;
  logic [BW-1:0] a_be = '0, b_be = '0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_din = '0, b_din = '0;

  logic [DW-1:0] dout_w [NI][2];
  logic          dv_w   [NI][2];
  logic          err_w  [NI][2];
  logic          ardy_w [NI];
  logic          brdy_w [NI];
  logic          busy_w [NI];

  always #5 ck = ~ck;

  bram_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BRAM_DEPTH(256), .READ_LATENCY(1), .INIT_FILE("")) u_dut_l1 (
    .ck(ck), .rst(rst),
    .a_req(a_req), .a_ready(ardy_w[0]), .a_wen(a_wen), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
    .a_dout(dout_w[0][0]), .a_dvalid(dv_w[0][0]), .a_err(err_w[0][0]),
    .b_req(b_req), .b_ready(brdy_w[0]), .b_wen(b_wen), .b_be(b_be), .b_addr(b_addr), .b_din(b_din),
    .b_dout(dout_w[0][1]), .b_dvalid(dv_w[0][1]), .b_err(err_w[0][1]),
    .busy(busy_w[0])
  );

  bram_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BRAM_DEPTH(200), .READ_LATENCY(2), .INIT_FILE("")) u_dut_l2 (
    .ck(ck), .rst(rst),
    .a_req(a_req), .a_ready(ardy_w[1]), .a_wen(a_wen), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
    .a_dout(dout_w[1][0]), .a_dvalid(dv_w[1][0]), .a_err(err_w[1][0]),
    .b_req(b_req), .b_ready(brdy_w[1]), .b_wen(b_wen), .b_be(b_be), .b_addr(b_addr), .b_din(b_din),
    .b_dout(dout_w[1][1]), .b_dvalid(dv_w[1][1]), .b_err(err_w[1][1]),
    .busy(busy_w[1])
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_en = 0;

  // Reference model: word array plus a schedule of what each output must show on a given cycle
  bit            up = 0;
  logic [DW-1:0] mm   [NI][256];
  bit            rv   [NI][2][RING];
  bit            re   [NI][2][RING];
  bit            we   [NI][2][RING];
  logic [DW-1:0] rd   [NI][2][RING];
  logic [DW-1:0] last [NI][2];

  typedef struct {
    int            inst;
    int            port;
    int            c;
    logic [DW-1:0] d;
    logic          e;
  } ev_t;
  ev_t evq[$];

  function automatic logic [DW-1:0] initv(input int k);
    return (32'(k) * 32'h0101_0101) ^ 32'hA500_005A;
  endfunction

  function automatic bit collide_now();
    return a_req && a_wen && b_req && b_wen && (a_addr == b_addr);
  endfunction

  task automatic model_reset();
    up = 0;
    for (int i = 0; i < NI; i++)
      for (int p = 0; p < 2; p++) begin
        last[i][p] = '0;
        for (int s = 0; s < RING; s++) begin
          rv[i][p][s] = 0;
          re[i][p][s] = 0;
          we[i][p][s] = 0;
          rd[i][p][s] = '0;
        end
      end
  endtask

  task automatic model_edge();
    bit            acc [2];
    bit            wr  [2];
    int            ad  [2];
    logic [BW-1:0] be  [2];
    logic [DW-1:0] din [2];
    acc[0] = up && a_req;
    acc[1] = up && b_req && !collide_now();
    wr[0] = a_wen;      wr[1] = b_wen;
    ad[0] = int'(a_addr); ad[1] = int'(b_addr);
    be[0] = a_be;       be[1] = b_be;
    din[0] = a_din;     din[1] = b_din;
    for (int i = 0; i < NI; i++) begin
      for (int p = 0; p < 2; p++)
        if (acc[p] && !wr[p]) begin
          int s;
          s = (cyc + lat[i]) % RING;
          rv[i][p][s] = 1;
          re[i][p][s] = ad[p] >= depth[i];
          rd[i][p][s] = (ad[p] >= depth[i]) ? 32'h0 : mm[i][ad[p]];
        end
      for (int p = 0; p < 2; p++)
        if (acc[p] && wr[p]) begin
          if (ad[p] >= depth[i]) we[i][p][cyc % RING] = 1;
          else
            for (int l = 0; l < BW; l++)
              if (be[p][l]) mm[i][ad[p]][8*l +: 8] = din[p][8*l +: 8];
        end
    end
    up = 1;
  endtask

  initial forever begin
    @(posedge ck);
    cyc++;
    if (rst) model_reset();
    else model_edge();
  end

  task automatic chk(input string nm, input int i, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d cyc=%0d actual=%h expected=%h", nm, i, cyc, act, exp);
    end
  endtask

  task automatic check_cycle();
    int  s;
    bit  exp_br;
    bit  bz;
    logic edv, eerr;
    s = cyc % RING;
    exp_br = up && !collide_now();
    for (int i = 0; i < NI; i++) begin
      bz = up && b_req && !exp_br;
      for (int k = 0; k <= lat[i]; k++)
        for (int p = 0; p < 2; p++)
          if (rv[i][p][(cyc + k) % RING]) bz = 1;
      chk("busy", i, 32'(busy_w[i]), 32'(bz));
      chk("a_ready", i, 32'(ardy_w[i]), 32'(up));
      chk("b_ready", i, 32'(brdy_w[i]), 32'(exp_br));
      for (int p = 0; p < 2; p++) begin
        edv  = rv[i][p][s];
        eerr = (rv[i][p][s] && re[i][p][s]) || we[i][p][s];
        if (edv) last[i][p] = rd[i][p][s];
        chk(p == 0 ? "a_dvalid" : "b_dvalid", i, 32'(dv_w[i][p]), 32'(edv));
        chk(p == 0 ? "a_err" : "b_err", i, 32'(err_w[i][p]), 32'(eerr));
        chk(p == 0 ? "a_dout" : "b_dout", i, dout_w[i][p], last[i][p]);
      end
    end
    for (int i = 0; i < NI; i++)
      for (int p = 0; p < 2; p++) begin
        rv[i][p][s] = 0;
        re[i][p][s] = 0;
        we[i][p][s] = 0;
      end
  endtask

  initial forever begin
    @(negedge ck);
    if (chk_en) begin
      check_cycle();
      for (int i = 0; i < NI; i++)
        for (int p = 0; p < 2; p++)
          if (dv_w[i][p] === 1'b1) evq.push_back('{i, p, cyc, dout_w[i][p], err_w[i][p]});
    end
  end

  task automatic get_ev(input int inst, input int port, input int nth, output bit found, output ev_t ev);
    int n;
    n = 0;
    found = 0;
    ev = '{0, 0, 0, '0, 1'b0};
    foreach (evq[j])
      if (!found && evq[j].inst == inst && evq[j].port == port) begin
        if (n == nth) begin
          found = 1;
          ev = evq[j];
        end
        n++;
      end
  endtask

  task automatic chk_ev(input string nm, input int i, input int port, input int nth,
                        input logic [DW-1:0] d, input int c_exp, input logic e);
    bit  f;
    ev_t ev;
    get_ev(i, port, nth, f, ev);
    if (!f) begin
      checks++;
      failures++;
      $display("FAIL %s_missing inst=%0d pulse=%0d actual=none expected=dvalid", nm, i, nth);
    end else begin
      chk({nm, "_data"}, i, ev.d, d);
      chk({nm, "_cycle"}, i, 32'(ev.c), 32'(c_exp));
      chk({nm, "_err"}, i, 32'(ev.e), 32'(e));
    end
  endtask

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic idle();
    a_req = 0;
    b_req = 0;
  endtask

  task automatic a_op(input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] d, input logic [BW-1:0] be);
    a_req = 1; a_wen = w; a_addr = ad; a_din = d; a_be = be;
  endtask

  task automatic b_op(input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] d, input logic [BW-1:0] be);
    b_req = 1; b_wen = w; b_addr = ad; b_din = d; b_be = be;
  endtask

  initial begin
    int acc;
    int cnt;
    int acc_s [8];
    logic [DW-1:0] exp_s [8];

    // Reset state
    repeat (2) @(posedge ck);
    #1;
    chk_en = 1;
    @(negedge ck);
    for (int i = 0; i < NI; i++) begin
      chk("rst_a_ready", i, 32'(ardy_w[i]), 32'h0);
      chk("rst_b_dout", i, dout_w[i][1], 32'h0);
      chk("rst_busy", i, 32'(busy_w[i]), 32'h0);
    end
    @(posedge ck);
    #1;
    rst = 0;
    @(negedge ck);
    chk("ready_before_edge", 0, 32'(ardy_w[0]), 32'h0);
    step();
    @(negedge ck);
    for (int i = 0; i < NI; i++) begin
      chk("ready_after_edge_a", i, 32'(ardy_w[i]), 32'h1);
      chk("ready_after_edge_b", i, 32'(brdy_w[i]), 32'h1);
    end

    // Fill the array from both ports at once
    for (int k = 0; k < 128; k++) begin
      a_op(1, 8'(k), initv(k), 4'hF);
      b_op(1, 8'(k + 128), initv(k + 128), 4'hF);
      step();
    end
    idle();

    // Reset while a read is in flight
    a_op(0, 8'd7, '0, '0);
    step();
    idle();
    rst = 1;
    model_reset();
    evq.delete();
    step();
    step();
    rst = 0;
    repeat (4) step();
    for (int i = 0; i < NI; i++) begin
      cnt = 0;
      foreach (evq[j]) if (evq[j].inst == i) cnt++;
      chk("midread_no_dvalid", i, 32'(cnt), 32'h0);
    end

    // Byte-lane merge
    a_op(1, 8'd5, 32'hFFFF_FFFF, 4'hF);
    step();
    a_op(1, 8'd5, 32'h1234_5678, 4'b0101);
    step();
    idle();
    b_op(0, 8'd5, '0, '0);
    step();
    acc = cyc;
    idle();
    evq.delete();
    repeat (4) step();
    for (int i = 0; i < NI; i++) chk_ev("be_merge", i, 1, 0, 32'hFF34_FF78, acc + lat[i], 1'b0);

    // Same-address write collision
    a_op(1, 8'h10, 32'hAAAA_AAAA, 4'hF);
    b_op(1, 8'h10, 32'hBBBB_BBBB, 4'hF);
    @(negedge ck);
    for (int i = 0; i < NI; i++) begin
      chk("coll_b_ready", i, 32'(brdy_w[i]), 32'h0);
      chk("coll_busy", i, 32'(busy_w[i]), 32'h1);
    end
    step();
    a_req = 0;
    @(negedge ck);
    chk("coll_b_ready_clear", 0, 32'(brdy_w[0]), 32'h1);
    step();
    idle();
    b_op(0, 8'h10, '0, '0);
    step();
    acc = cyc;
    idle();
    evq.delete();
    repeat (4) step();
    for (int i = 0; i < NI; i++) chk_ev("coll_last_writer", i, 1, 0, 32'hBBBB_BBBB, acc + lat[i], 1'b0);

    // Cross-port read-first
    a_op(1, 8'd3, 32'h1111_1111, 4'hF);
    step();
    a_op(1, 8'd3, 32'h2222_2222, 4'hF);
    b_op(0, 8'd3, '0, '0);
    step();
    acc = cyc;
    evq.delete();
    a_req = 0;
    step();
    idle();
    repeat (4) step();
    for (int i = 0; i < NI; i++) begin
      chk_ev("read_first_old", i, 1, 0, 32'h1111_1111, acc + lat[i], 1'b0);
      chk_ev("read_first_new", i, 1, 1, 32'h2222_2222, acc + 1 + lat[i], 1'b0);
    end

    // Back-to-back streaming reads
    evq.delete();
    for (int k = 0; k < 8; k++) begin
      exp_s[k] = (k == 3) ? 32'h2222_2222 : (k == 5) ? 32'hFF34_FF78 : initv(k);
      b_op(0, 8'(k), '0, '0);
      step();
      acc_s[k] = cyc;
      @(negedge ck);
      for (int i = 0; i < NI; i++) chk("stream_busy", i, 32'(busy_w[i]), 32'h1);
    end
    idle();
    repeat (4) step();
    for (int i = 0; i < NI; i++)
      for (int k = 0; k < 8; k++) chk_ev("stream", i, 1, k, exp_s[k], acc_s[k] + lat[i], 1'b0);

    // Out-of-range on the 200-word instance (in range on the 256-word one)
    a_op(1, 8'd250, 32'hDEAD_BEEF, 4'hF);
    step();
    idle();
    @(negedge ck);
    chk("oor_wr_err", 1, 32'(err_w[1][0]), 32'h1);
    chk("inrange_wr_err", 0, 32'(err_w[0][0]), 32'h0);
    a_op(0, 8'd250, '0, '0);
    step();
    acc = cyc;
    idle();
    evq.delete();
    repeat (4) step();
    chk_ev("oor_rd", 1, 0, 0, 32'h0, acc + 2, 1'b1);
    chk_ev("inrange_rd", 0, 0, 0, 32'hDEAD_BEEF, acc + 1, 1'b0);

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
